// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared types and default geometry for the data cache controller
// Contents: default line count / line size, derived address field widths,
// controller state encoding and the packed line type for the default geometry.
package dcache_pkg;

  localparam int NUM_LINES_DEF  = 4;
  localparam int LINE_WORDS_DEF = 4;

  // Byte offset covers the word select plus the two ignored byte bits.
  localparam int OFF_W_DEF = $clog2(LINE_WORDS_DEF) + 2;
  localparam int IDX_W_DEF = $clog2(NUM_LINES_DEF);
  localparam int TAG_W_DEF = 32 - OFF_W_DEF - IDX_W_DEF;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_REFILL    = 2'd2
  } dcache_state_t;

  // Word i of a line sits at bits [32*i +: 32]; same layout as mem_wdata/mem_rdata.
  typedef logic [LINE_WORDS_DEF-1:0][31:0] line_t;

endpackage

// File: rtl/dcache_line_store.sv
// rtl/dcache_line_store.sv - valid/dirty/tag/data arrays for a direct-mapped cache
// Ports:
//   clock, reset                    clock and synchronous active-high reset (clears valid/dirty)
//   rd_index -> rd_valid/rd_dirty/rd_tag/rd_line   single combinational read port
//   word_we/word_index/word_sel/word_data          word store, also marks the line dirty
//   line_we/line_index/line_tag/line_data          whole-line refill, line becomes valid+clean
//   clean_we/clean_index                           clears dirty after a writeback
module dcache_line_store #(
  parameter int NUM_LINES  = 4,
  parameter int LINE_WORDS = 4,
  parameter int TAG_W      = 26,
  parameter int IDX_W      = $clog2(NUM_LINES),
  parameter int WSEL_W     = $clog2(LINE_WORDS)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [IDX_W-1:0]         rd_index,
  output logic                     rd_valid,
  output logic                     rd_dirty,
  output logic [TAG_W-1:0]         rd_tag,
  output logic [32*LINE_WORDS-1:0] rd_line,
  input  logic                     word_we,
  input  logic [IDX_W-1:0]         word_index,
  input  logic [WSEL_W-1:0]        word_sel,
  input  logic [31:0]              word_data,
  input  logic                     line_we,
  input  logic [IDX_W-1:0]         line_index,
  input  logic [TAG_W-1:0]         line_tag,
  input  logic [32*LINE_WORDS-1:0] line_data,
  input  logic                     clean_we,
  input  logic [IDX_W-1:0]         clean_index
);

  logic [NUM_LINES-1:0]     valid_q;
  logic [NUM_LINES-1:0]     dirty_q;
  logic [TAG_W-1:0]         tag_q  [NUM_LINES];
  logic [32*LINE_WORDS-1:0] data_q [NUM_LINES];

  assign rd_valid = valid_q[rd_index];
  assign rd_dirty = dirty_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_line  = data_q[rd_index];

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (line_we) begin
        valid_q[line_index] <= 1'b1;
        dirty_q[line_index] <= 1'b0;
      end
      if (clean_we) dirty_q[clean_index] <= 1'b0;
      if (word_we)  dirty_q[word_index]  <= 1'b1;
    end
  end

  // Tags and data carry no reset; they are meaningless until valid is set.
  always_ff @(posedge clock) begin
    if (line_we) begin
      tag_q[line_index]  <= line_tag;
      data_q[line_index] <= line_data;
    end
    if (word_we) data_q[word_index][{word_sel, 5'd0} +: 32] <= word_data;
  end

endmodule

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-back data cache controller
// Ports:
//   clock, reset                 clock and synchronous active-high reset
//   cpu_req/cpu_we/cpu_addr/cpu_wdata   MEM-stage word access (held while stalled)
//   cpu_rdata                    load data, combinational on an IDLE hit
//   dcache_stall                 holds the pipeline on a miss and during line transfers
//   mem_req/mem_we/mem_addr/mem_wdata   registered line transfer request (we=1 writeback)
//   mem_rdata/mem_ack            refill line and one-cycle completion pulse
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int NUM_LINES  = NUM_LINES_DEF,
  parameter int LINE_WORDS = LINE_WORDS_DEF
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic [31:0]              cpu_addr,
  input  logic [31:0]              cpu_wdata,
  output logic [31:0]              cpu_rdata,
  output logic                     dcache_stall,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [31:0]              mem_addr,
  output logic [32*LINE_WORDS-1:0] mem_wdata,
  input  logic [32*LINE_WORDS-1:0] mem_rdata,
  input  logic                     mem_ack
);

  localparam int WSEL_W = $clog2(LINE_WORDS);
  localparam int OFF_W  = WSEL_W + 2;
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int TAG_W  = 32 - OFF_W - IDX_W;

  logic [WSEL_W-1:0] word_sel;
  logic [IDX_W-1:0]  index;
  logic [TAG_W-1:0]  tag;
  logic              unused_byte_bits;

  assign word_sel         = cpu_addr[OFF_W-1:2];
  assign index            = cpu_addr[OFF_W+IDX_W-1:OFF_W];
  assign tag              = cpu_addr[31:OFF_W+IDX_W];
  assign unused_byte_bits = ^cpu_addr[1:0];

  dcache_state_t           state_q;
  logic                    mem_req_q;
  logic                    mem_we_q;
  logic [31:0]             mem_addr_q;
  logic [32*LINE_WORDS-1:0] mem_wdata_q;

  logic                     rd_valid;
  logic                     rd_dirty;
  logic [TAG_W-1:0]         rd_tag;
  logic [32*LINE_WORDS-1:0] rd_line;

  logic hit, in_idle, miss, xfer_done;
  logic word_we, line_we, clean_we;

  assign hit       = cpu_req && rd_valid && (rd_tag == tag);
  assign in_idle   = (state_q == ST_IDLE);
  assign miss      = in_idle && cpu_req && !hit;
  // An ack only completes a transfer we are actually requesting; anything else is stray.
  assign xfer_done = mem_req_q && mem_ack;

  assign dcache_stall = !reset && (!in_idle || miss);
  assign cpu_rdata    = rd_line[{word_sel, 5'd0} +: 32];

  assign word_we  = !reset && in_idle && hit && cpu_we;
  assign line_we  = !reset && (state_q == ST_REFILL) && xfer_done;
  assign clean_we = !reset && (state_q == ST_WRITEBACK) && xfer_done;

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  dcache_line_store #(
    .NUM_LINES (NUM_LINES),
    .LINE_WORDS(LINE_WORDS),
    .TAG_W     (TAG_W),
    .IDX_W     (IDX_W),
    .WSEL_W    (WSEL_W)
  ) u_store (
    .clock      (clock),
    .reset      (reset),
    .rd_index   (index),
    .rd_valid   (rd_valid),
    .rd_dirty   (rd_dirty),
    .rd_tag     (rd_tag),
    .rd_line    (rd_line),
    .word_we    (word_we),
    .word_index (index),
    .word_sel   (word_sel),
    .word_data  (cpu_wdata),
    .line_we    (line_we),
    .line_index (index),
    .line_tag   (tag),
    .line_data  (mem_rdata),
    .clean_we   (clean_we),
    .clean_index(index)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (miss) begin
            mem_req_q   <= 1'b1;
            mem_wdata_q <= rd_line;
            if (rd_valid && rd_dirty) begin
              state_q    <= ST_WRITEBACK;
              mem_we_q   <= 1'b1;
              mem_addr_q <= {rd_tag, index, {OFF_W{1'b0}}};
            end else begin
              state_q    <= ST_REFILL;
              mem_we_q   <= 1'b0;
              mem_addr_q <= {tag, index, {OFF_W{1'b0}}};
            end
          end
        end
        ST_WRITEBACK: begin
          // Drop mem_req for one cycle so the refill is a distinct request.
          if (xfer_done) begin
            state_q   <= ST_REFILL;
            mem_req_q <= 1'b0;
          end
        end
        ST_REFILL: begin
          if (!mem_req_q) begin
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= {tag, index, {OFF_W{1'b0}}};
          end else if (mem_ack) begin
            state_q   <= ST_IDLE;
            mem_req_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 Parameter NUM_LINES, 4, number of direct-mapped lines (power of two, >=2).
REQ-002 Parameter LINE_WORDS, 4, 32-bit words per line (power of two).
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cpu_req  input  1  MEM-stage access valid this cycle.
REQ-006 cpu_we  input  1  1 = word store, 0 = word load.
REQ-007 cpu_addr  input  32  byte address; bits [1:0] ignored.
REQ-008 cpu_wdata  input  32  store data.
REQ-009 cpu_rdata  output  32  load data, valid when cpu_req && !dcache_stall.
REQ-010 dcache_stall  output  1  drives ctrl_signals.dcache_stall; pipeline holds MEM and bubbles MEM/WB while high.
REQ-011 mem_req  output  1  line transfer request to memory.
REQ-012 mem_we  output  1  1 = writeback, 0 = refill.
REQ-013 mem_addr  output  32  line-aligned address.
REQ-014 mem_wdata  output  32*LINE_WORDS  victim line for writeback.
REQ-015 mem_rdata  input  32*LINE_WORDS  refill line, valid with mem_ack.
REQ-016 mem_ack  input  1  one-cycle completion pulse, arbitrary latency >=1 cycle after mem_req rises.

Function
REQ-017 Address split: offset = [log2(LINE_WORDS)+1:0], index = next log2(NUM_LINES) bits, tag = remaining upper bits.
REQ-018 Per line: valid bit, dirty bit, tag, data; hit = cpu_req && valid[index] && tag match.
REQ-019 FSM states IDLE, WRITEBACK, REFILL; reset state IDLE.
REQ-020 IDLE hit load: cpu_rdata = selected word combinationally, same cycle, dcache_stall=0.
REQ-021 IDLE hit store: word written and dirty set on the same rising edge, dcache_stall=0.
REQ-022 IDLE miss, victim clean or invalid: dcache_stall=1 combinationally; next state REFILL.
REQ-023 IDLE miss, victim valid and dirty: dcache_stall=1; next state WRITEBACK.
REQ-024 WRITEBACK: mem_req=1, mem_we=1, mem_addr = {victim tag, index, zero offset}, mem_wdata = victim line; on mem_ack -> REFILL, dirty cleared.
REQ-025 REFILL: mem_req=1, mem_we=0, mem_addr = line address of cpu_addr; on mem_ack line data, tag written, valid=1, dirty=0, -> IDLE.
REQ-026 dcache_stall=1 in WRITEBACK and REFILL, including the mem_ack cycle; the retried access hits in IDLE the following cycle (store miss merges on that hit).
REQ-027 mem_req, mem_we, mem_addr, mem_wdata stable from request until mem_ack; mem_req deasserts the cycle after mem_ack.
REQ-028 cpu_addr/cpu_we/cpu_wdata held stable by pipeline while dcache_stall=1; cpu_req deassert in WRITEBACK/REFILL does not abort transfer.
REQ-029 mem_ack in IDLE ignored.
REQ-030 Minimum miss penalty: clean miss 2 stall cycles (mem_ack 1 cycle after request); dirty miss adds writeback latency.

Reset
REQ-031 On reset: state IDLE, all valid and dirty cleared, mem_req=0, mem_we=0, dcache_stall=0; data/tag contents unspecified.
REQ-032 Reset mid-WRITEBACK or mid-REFILL abandons transfer; mem_req low in the cycle after reset asserts; late mem_ack ignored.
REQ-033 cpu_rdata value undefined under reset; no writes occur while reset high.

Structure
REQ-034 Shared package holds dcache_state_t enum, line_t packed type, NUM_LINES/LINE_WORDS defaults and derived field widths.
REQ-035 One sub-module dcache_line_store: valid/dirty/tag/data arrays with single read port and word/line write ports; FSM stays in dcache_ctrl.
REQ-036 mem_* outputs driven from registered state only; dcache_stall may be combinational from hit logic.

Verification
REQ-037 Reset, load 0x0000_0040 -> stall, REFILL mem_addr=0x40, ack after 3 cycles with word1=0xDEADBEEF at 0x44 then load 0x44 -> cpu_rdata=0xDEADBEEF, no stall.
REQ-038 Store 0x12345678 to 0x40 (hit) then load 0x40 -> 0x12345678 next cycle, zero stall cycles, line dirty.
REQ-039 Load 0x80 (same index, dirty victim) -> WRITEBACK mem_addr=0x40 with mem_wdata word0=0x12345678, then REFILL mem_addr=0x80.
REQ-040 Store miss to 0x100 -> REFILL, then store hits, subsequent load 0x100 returns stored data, line dirty.
REQ-041 Reset asserted during REFILL before mem_ack -> mem_req=0 next cycle, load to same address misses again.
REQ-042 mem_ack pulsed while IDLE and no miss -> no state, valid, or data change.
